// File: rtl/sprite_line_evaluator_pkg.sv
// Shared types and defaults for the sprite line evaluator: OAM entry layout,
// stored hit record and controller states.
package sprite_line_evaluator_pkg;

    localparam int unsigned PPU_LINES       = 480;
    localparam int unsigned NUM_OAM_DEF     = 64;
    localparam int unsigned MAX_SPRITES_DEF = 8;
    localparam int unsigned SPR_H_DEF       = 16;

    typedef struct packed {
        logic       enable;
        logic [2:0] palette;
        logic [7:0] tile;
        logic [9:0] y;
        logic [9:0] x;
    } oam_entry_t;

    typedef struct packed {
        logic [7:0] tile;
        logic [9:0] x;
        logic [2:0] palette;
        logic [3:0] row;
    } sprite_hit_t;

    localparam int unsigned HIT_W = $bits(sprite_hit_t);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFetch,
        StDone
    } state_e;

endpackage

// File: rtl/sprite_line_evaluator_hit_table.sv
// Write-in-order register file of sprite hits for one scanline, with an indexed read port.
module sprite_line_evaluator_hit_table
    import sprite_line_evaluator_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_SPRITES_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [HIT_W-1:0] i_data,
    input  logic [2:0]       i_rd_idx,
    output logic [HIT_W-1:0] o_rd_data,
    output logic [3:0]       o_count,
    output logic             o_full
);

    logic [HIT_W-1:0] r_mem [DEPTH];
    logic [3:0]       r_count;

    assign o_full    = (r_count == 4'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[i_rd_idx];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_count[2:0]] <= i_data;
            r_count             <= r_count + 4'd1;
        end
    end

endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluation: scans OAM during hblank, fetches the rows of the hit
// sprites and loads every shift-register slot in order, unused slots as transparent.
module sprite_line_evaluator
    import sprite_line_evaluator_pkg::*;
#(
    parameter int unsigned NUM_OAM     = NUM_OAM_DEF,
    parameter int unsigned MAX_SPRITES = MAX_SPRITES_DEF,
    parameter int unsigned SPR_H       = SPR_H_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_line_start,
    input  logic [9:0]  i_next_line,
    output logic [5:0]  o_oam_addr,
    input  logic [31:0] i_oam_rdata,
    output logic [11:0] o_spr_addr,
    input  logic [63:0] i_spr_rdata,
    output logic        o_load,
    output logic [2:0]  o_load_slot,
    output logic [63:0] o_load_pixels,
    output logic [9:0]  o_load_x,
    output logic [2:0]  o_load_palette,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow,
    output logic [3:0]  o_sprite_count
);

    state_e      r_state, w_state_next;
    logic [6:0]  r_idx, w_idx_next;
    logic [9:0]  r_line;
    logic        r_cmp_valid;
    logic        r_overflow;
    logic        r_load;
    logic        r_load_used;
    logic [2:0]  r_load_slot;
    logic [9:0]  r_load_x;
    logic [2:0]  r_load_pal;

    oam_entry_t       w_entry;
    sprite_hit_t      w_new_hit;
    sprite_hit_t      w_rd_hit;
    logic [HIT_W-1:0] w_rd_data;
    logic [9:0]       w_diff;
    logic             w_hit;
    logic             w_start;
    logic             w_full;
    logic [3:0]       w_count;
    logic             w_fetch_issue;
    logic             w_slot_used;

    assign w_entry = oam_entry_t'(i_oam_rdata);
    assign w_diff  = r_line - w_entry.y;
    // The >= guard keeps sprites below the line from wrapping into a hit.
    assign w_hit   = r_cmp_valid && w_entry.enable && (r_line >= w_entry.y)
                     && (w_diff < 10'(SPR_H));
    assign w_start = (r_state == StIdle) && i_line_start;

    assign w_new_hit = '{tile: w_entry.tile, x: w_entry.x, palette: w_entry.palette,
                         row: w_diff[3:0]};
    assign w_rd_hit  = sprite_hit_t'(w_rd_data);

    assign w_fetch_issue = (r_state == StFetch) && (r_idx < 7'(MAX_SPRITES));
    assign w_slot_used   = (r_idx < {3'b000, w_count});

    sprite_line_evaluator_hit_table #(
        .DEPTH (MAX_SPRITES)
    ) u_hit_table (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_start),
        .i_push    (w_hit && !w_full),
        .i_data    (w_new_hit),
        .i_rd_idx  (r_idx[2:0]),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (i_line_start) begin
                    w_state_next = StScan;
                    w_idx_next   = '0;
                end
            end
            // One extra cycle at the end lets the last OAM read be compared.
            StScan: begin
                if (r_idx == 7'(NUM_OAM)) begin
                    w_state_next = StFetch;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 7'd1;
                end
            end
            StFetch: begin
                if (r_idx == 7'(MAX_SPRITES)) begin
                    w_state_next = StDone;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 7'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_line      <= '0;
            r_cmp_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_load      <= 1'b0;
            r_load_used <= 1'b0;
            r_load_slot <= '0;
            r_load_x    <= '0;
            r_load_pal  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_cmp_valid <= (r_state == StScan) && (r_idx < 7'(NUM_OAM));
            if (w_start) begin
                r_line     <= i_next_line;
                r_overflow <= 1'b0;
            end else if (w_hit && w_full) begin
                r_overflow <= 1'b1;
            end
            r_load      <= w_fetch_issue;
            r_load_used <= w_fetch_issue && w_slot_used;
            r_load_slot <= w_fetch_issue ? r_idx[2:0] : 3'd0;
            r_load_x    <= (w_fetch_issue && w_slot_used) ? w_rd_hit.x : 10'd0;
            r_load_pal  <= (w_fetch_issue && w_slot_used) ? w_rd_hit.palette : 3'd0;
        end
    end

    assign o_oam_addr     = (r_state == StScan) ? r_idx[5:0] : 6'd0;
    assign o_spr_addr     = w_fetch_issue ? {w_rd_hit.tile, w_rd_hit.row} : 12'd0;
    assign o_load         = r_load;
    assign o_load_slot    = r_load_slot;
    assign o_load_pixels  = r_load_used ? i_spr_rdata : 64'd0;
    assign o_load_x       = r_load_x;
    assign o_load_palette = r_load_pal;
    assign o_busy         = (r_state != StIdle);
    assign o_done         = (r_state == StDone);
    assign o_overflow     = r_overflow;
    assign o_sprite_count = w_count;

endmodule
